// File: rtl/vmem_requestor.sv
// Initiator for the vector memory request bus: runs one store or load burst at a time
// and buffers returned load beats in a small FIFO that drains independently of the FSM.
module vmem_requestor #(
   parameter int ADDR_RANGE   = 32768,
   parameter int LENGTH_RANGE = 32,
   parameter int BUS_WIDTH    = 32,
   parameter int FIFO_DEPTH   = 4,
   localparam int AW = $clog2(ADDR_RANGE),
   localparam int LW = $clog2(LENGTH_RANGE) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_cmd_valid,
   output logic                 o_cmd_ready,
   input  logic                 i_cmd_store,
   input  logic [AW-1:0]        i_cmd_addr,
   input  logic [LW-1:0]        i_cmd_length,
   input  logic [1:0]           i_cmd_mode,
   input  logic                 i_st_valid,
   output logic                 o_st_ready,
   input  logic [BUS_WIDTH-1:0] i_st_data,
   output logic                 o_ld_valid,
   input  logic                 i_ld_ready,
   output logic [BUS_WIDTH-1:0] o_ld_data,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [BUS_WIDTH-1:0] o_wrdata,
   output logic [AW-1:0]        o_addr,
   output logic [LW-1:0]        o_length,
   output logic [1:0]           o_mode_out,
   output logic                 o_wr,
   output logic                 o_rd,
   output logic                 o_rddataready,
   input  logic                 i_ready,
   input  logic                 i_rddatavalid,
   input  logic [BUS_WIDTH-1:0] i_rddata
);

   // state | meaning
   // IDLE  | no burst; command port open
   // WRITE | store burst, beats move on st_valid & ready
   // READ  | load burst, beats move on rddatavalid & !fifo_full
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2
   } state_t;

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [AW-1:0]        r_addr;
   logic [LW-1:0]        r_length;
   logic [1:0]           r_mode;
   logic [LW-1:0]        r_beat_cnt;
   logic                 r_done;

   logic [BUS_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]        r_wptr;
   logic [PW-1:0]        r_rptr;
   logic [CW-1:0]        r_count;

   logic w_full;
   logic w_empty;
   logic w_accept;
   logic w_accept_zero;
   logic w_wr_beat;
   logic w_rd_beat;
   logic w_beat;
   logic w_last;
   logic w_pop;

   assign w_full        = (r_count == CW'(FIFO_DEPTH));
   assign w_empty       = (r_count == '0);
   assign w_accept      = (r_state == S_IDLE) & i_cmd_valid;
   assign w_accept_zero = w_accept & (i_cmd_length == '0);
   assign w_wr_beat     = (r_state == S_WRITE) & i_st_valid & i_ready;
   assign w_rd_beat     = (r_state == S_READ) & i_rddatavalid & ~w_full;
   assign w_beat        = w_wr_beat | w_rd_beat;
   assign w_last        = w_beat & (r_beat_cnt == (r_length - LW'(1)));
   assign w_pop         = ~w_empty & i_ld_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      o_wr          = 1'b0;
      o_rd          = 1'b0;
      o_rddataready = 1'b0;
      o_st_ready    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_cmd_valid && (i_cmd_length != '0))
               w_state_nxt = i_cmd_store ? S_WRITE : S_READ;
         end
         S_WRITE: begin
            o_wr       = i_st_valid;
            o_st_ready = i_ready;
            if (w_last) w_state_nxt = S_IDLE;
         end
         S_READ: begin
            o_rd          = 1'b1;
            o_rddataready = ~w_full;
            if (w_last) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Bus fields are captured once per command and left in place after the burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr     <= '0;
         r_length   <= '0;
         r_mode     <= '0;
         r_beat_cnt <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= w_accept_zero | w_last;
         if (w_accept) begin
            r_addr     <= i_cmd_addr;
            r_length   <= i_cmd_length;
            r_mode     <= i_cmd_mode;
            r_beat_cnt <= '0;
         end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + LW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_rd_beat) r_mem[r_wptr] <= i_rddata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_rd_beat) r_wptr <= r_wptr + PW'(1);
         if (w_pop)     r_rptr <= r_rptr + PW'(1);
         case ({w_rd_beat, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_cmd_ready = (r_state == S_IDLE);
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = r_done;
   assign o_addr      = r_addr;
   assign o_length    = r_length;
   assign o_mode_out  = r_mode;
   assign o_wrdata    = i_st_data;
   assign o_ld_valid  = ~w_empty;
   assign o_ld_data   = r_mem[r_rptr];

endmodule

// File: tb/tb_vmem_requestor.sv
// Bench for vmem_requestor: directed bursts plus random traffic, checked every cycle
// against a burst/queue model of the requestor.
module tb_vmem_requestor;
   localparam int AW = 15;
   localparam int LW = 6;
   localparam int BW = 32;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid, cmd_store;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_length;
   logic [1:0]    cmd_mode;
   logic          st_valid, ld_ready, ready, rddatavalid;
   logic [BW-1:0] st_data, rddata;
   logic          o_cmd_ready, o_st_ready, o_ld_valid, o_busy, o_done;
   logic          o_wr, o_rd, o_rddataready;
   logic [BW-1:0] o_ld_data, o_wrdata;
   logic [AW-1:0] o_addr;
   logic [LW-1:0] o_length;
   logic [1:0]    o_mode_out;

   always #5 clk = ~clk;

   vmem_requestor #(.ADDR_RANGE(32768), .LENGTH_RANGE(32), .BUS_WIDTH(BW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_store(cmd_store),
      .i_cmd_addr(cmd_addr), .i_cmd_length(cmd_length), .i_cmd_mode(cmd_mode),
      .i_st_valid(st_valid), .o_st_ready(o_st_ready), .i_st_data(st_data),
      .o_ld_valid(o_ld_valid), .i_ld_ready(ld_ready), .o_ld_data(o_ld_data),
      .o_busy(o_busy), .o_done(o_done), .o_wrdata(o_wrdata), .o_addr(o_addr),
      .o_length(o_length), .o_mode_out(o_mode_out), .o_wr(o_wr), .o_rd(o_rd),
      .o_rddataready(o_rddataready), .i_ready(ready), .i_rddatavalid(rddatavalid),
      .i_rddata(rddata)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a burst is "beats left to move"; load data is a plain queue.
   bit            m_busy = 0, m_store = 0, m_done = 0;
   logic [AW-1:0] m_addr = '0;
   logic [LW-1:0] m_len = '0;
   logic [1:0]    m_mode = '0;
   int            m_left = 0;
   logic [BW-1:0] m_q[$];

   always @(posedge clk or posedge rst) begin : model
      bit push, pop, nd;
      if (rst) begin
         m_busy = 0; m_store = 0; m_done = 0;
         m_addr = '0; m_len = '0; m_mode = '0; m_left = 0;
         m_q.delete();
      end else begin
         nd   = 0;
         push = m_busy && !m_store && rddatavalid && (m_q.size() < FD);
         pop  = (m_q.size() > 0) && ld_ready;
         if (!m_busy) begin
            if (cmd_valid) begin
               m_addr  = cmd_addr;
               m_len   = cmd_length;
               m_mode  = cmd_mode;
               m_store = cmd_store;
               m_left  = int'(cmd_length);
               if (m_left == 0) nd = 1;
               else m_busy = 1;
            end
         end else if ((m_store && st_valid && ready) || push) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 0;
               nd = 1;
            end
         end
         if (pop) void'(m_q.pop_front());
         if (push) m_q.push_back(rddata);
         m_done = nd;
      end
   end

   always @(negedge clk) begin
      chk("cmd_ready", o_cmd_ready, !m_busy);
      chk("busy", o_busy, m_busy);
      chk("done", o_done, m_done);
      chk("addr", o_addr, m_addr);
      chk("length", o_length, m_len);
      chk("mode_out", o_mode_out, m_mode);
      chk("wr", o_wr, m_busy && m_store && st_valid);
      chk("st_ready", o_st_ready, m_busy && m_store && ready);
      chk("rd", o_rd, m_busy && !m_store);
      chk("rddataready", o_rddataready, m_busy && !m_store && (m_q.size() < FD));
      chk("ld_valid", o_ld_valid, m_q.size() > 0);
      chk("wrdata", o_wrdata, st_data);
      if (m_q.size() > 0) chk("ld_data", o_ld_data, m_q[0]);
   end

   // Observed traffic, used for hand-computed checks.
   logic [BW-1:0] wlog[$];
   logic [BW-1:0] ldlog[$];
   int pushcnt = 0;
   int donecnt = 0;
   always @(negedge clk) begin
      if (o_wr && ready) wlog.push_back(o_wrdata);
      if (o_rddataready && rddatavalid) pushcnt++;
      if (o_ld_valid && ld_ready) ldlog.push_back(o_ld_data);
      if (o_done) donecnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cmd_valid = 0; cmd_store = 0; cmd_addr = '0; cmd_length = '0; cmd_mode = '0;
      st_valid = 0; st_data = '0; ld_ready = 0; ready = 0; rddatavalid = 0; rddata = '0;
   endtask

   task automatic issue(input bit store, input int addr, input int len, input int mode);
      cmd_valid = 1; cmd_store = store; cmd_addr = AW'(addr);
      cmd_length = LW'(len); cmd_mode = 2'(mode);
      step();
      cmd_valid = 0;
   endtask

   logic [BW-1:0] dpat[4] = '{32'hD000_0000, 32'hD111_1111, 32'hD222_2222, 32'hD333_3333};
   logic [BW-1:0] rpat[6] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};

   initial begin
      int d0, p0, l0, w0, n;
      idle_inputs();
      #1 rst = 1;
      #2 chk("rst_cmd_ready", o_cmd_ready, 1);
      chk("rst_busy", o_busy, 0);
      step(); step();
      rst = 0;
      step();

      // store len 4, ready 1,0,1,1,1
      wlog.delete(); d0 = donecnt;
      st_valid = 1; st_data = dpat[0];
      issue(1, 'h10, 4, 1);
      ready = 1; st_data = dpat[0]; step();
      ready = 0; st_data = dpat[1]; step();
      ready = 1; step();
      st_data = dpat[2]; step();
      st_data = dpat[3]; step();
      chk("store_done_pulse", o_done, 1);
      ready = 0; st_valid = 0; step();
      chk("store_beats", wlog.size(), 4);
      for (int i = 0; i < 4 && i < wlog.size(); i++) chk("store_data", wlog[i], dpat[i]);
      chk("store_addr", o_addr, 'h10);
      chk("store_done_cnt", donecnt - d0, 1);

      // load len 6 into a 4-deep FIFO with the sink stalled
      ldlog.delete(); d0 = donecnt; p0 = pushcnt;
      issue(0, 'h20, 6, 0);
      rddatavalid = 1;
      for (int i = 0; i < 8; i++) begin
         rddata = rpat[(pushcnt - p0) < 6 ? (pushcnt - p0) : 5];
         step();
      end
      chk("load_pushed_before_full", pushcnt - p0, 4);
      chk("load_stalled_rdr", o_rddataready, 0);
      chk("load_still_busy", o_busy, 1);
      ld_ready = 1;
      n = 0;
      while ((o_busy || ldlog.size() < 6) && n < 40) begin
         rddata = rpat[(pushcnt - p0) < 6 ? (pushcnt - p0) : 5];
         step(); n++;
      end
      chk("load_timeout", n < 40, 1);
      rddatavalid = 0; ld_ready = 0; step();
      chk("load_pops", ldlog.size(), 6);
      for (int i = 0; i < 6 && i < ldlog.size(); i++) chk("load_data", ldlog[i], rpat[i]);
      chk("load_done_cnt", donecnt - d0, 1);

      // zero-length store and load
      d0 = donecnt; w0 = wlog.size(); p0 = pushcnt;
      st_valid = 1; ready = 1; rddatavalid = 1;
      issue(1, 'h30, 0, 1);
      chk("zero_done", o_done, 1);
      chk("zero_cmd_ready", o_cmd_ready, 1);
      issue(0, 'h31, 0, 0);
      step(); step();
      chk("zero_done_cnt", donecnt - d0, 2);
      chk("zero_no_wr", wlog.size(), w0);
      chk("zero_no_rd", pushcnt, p0);
      st_valid = 0; ready = 0; rddatavalid = 0;

      // store len 1
      d0 = donecnt; w0 = wlog.size();
      issue(1, 'h44, 1, 0);
      st_valid = 1; ready = 1; st_data = 32'h1234_5678; step();
      chk("single_idle", o_cmd_ready, 1);
      st_valid = 0; ready = 0; step(); step();
      chk("single_beats", wlog.size() - w0, 1);
      chk("single_done_cnt", donecnt - d0, 1);

      // back-to-back: load 2 held in FIFO, then store 2 at F+1
      l0 = ldlog.size();
      issue(0, 'h50, 2, 1);
      rddatavalid = 1; rddata = 32'hB0;
      n = 0;
      while (o_busy && n < 10) begin step(); rddata = 32'hB1; n++; end
      chk("b2b_load_timeout", n < 10, 1);
      rddatavalid = 0; w0 = wlog.size();
      issue(1, 'h60, 2, 1);
      st_valid = 1; ready = 1; st_data = 32'hC0;
      n = 0;
      while (o_busy && n < 10) begin step(); st_data = 32'hC1; n++; end
      chk("b2b_store_timeout", n < 10, 1);
      st_valid = 0; ready = 0; step();
      chk("b2b_store_beats", wlog.size() - w0, 2);
      chk("b2b_fifo_kept", o_ld_valid, 1);
      chk("b2b_no_pops", ldlog.size(), l0);
      ld_ready = 1; step(); step(); step(); ld_ready = 0;

      // reset during beat 2 of a len-5 store
      issue(1, 'h70, 5, 1);
      st_valid = 1; ready = 1; step();
      rst = 1;
      #2 chk("rst_mid_busy", o_busy, 0);
      chk("rst_mid_wr", o_wr, 0);
      chk("rst_mid_addr", o_addr, 0);
      chk("rst_mid_len", o_length, 0);
      step();
      rst = 0; st_valid = 0; ready = 0;
      step();
      d0 = donecnt; l0 = ldlog.size();
      issue(0, 'h71, 1, 0);
      rddatavalid = 1; rddata = 32'hE0; ld_ready = 1;
      n = 0;
      while (o_busy && n < 10) begin step(); n++; end
      rddatavalid = 0;
      step(); step();
      chk("post_rst_done", donecnt - d0, 1);
      chk("post_rst_pop", ldlog.size() - l0, 1);
      if (ldlog.size() > l0) chk("post_rst_data", ldlog[l0], 32'hE0);
      ld_ready = 0;

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         cmd_valid   = ($urandom_range(0, 3) == 0);
         cmd_store   = $urandom_range(0, 1);
         cmd_addr    = AW'($urandom);
         cmd_length  = ($urandom_range(0, 15) == 0) ? LW'(32) : LW'($urandom_range(0, 7));
         cmd_mode    = 2'($urandom);
         st_valid    = $urandom_range(0, 1);
         st_data     = $urandom;
         ready       = ($urandom_range(0, 2) != 0);
         rddatavalid = $urandom_range(0, 1);
         rddata      = $urandom;
         ld_ready    = ($urandom_range(0, 2) == 0);
         rst         = ($urandom_range(0, 599) == 0);
         step();
      end
      rst = 0;
      idle_inputs();
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
